// File: rtl/clkmon_edge_counter.sv
// Clock-net edge counter: counts synchronized rising edges of I over a fixed
// window of CLK cycles and flags counts outside [LO_TH, HI_TH] or stuck at zero.
module clkmon_edge_counter #(
    parameter int unsigned WIN_CYCLES  = 256,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             I,
    input  logic [CNT_W-1:0] LO_TH,
    input  logic [CNT_W-1:0] HI_TH,
    output logic [CNT_W-1:0] CNT,
    output logic             VALID,
    output logic             FAIL,
    output logic             STUCK,
    output logic             BUSY
);
    localparam int unsigned WIN_W = $clog2(WIN_CYCLES);
    localparam int unsigned ARM_W = $clog2(SYNC_STAGES);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES - 1);

    typedef enum logic [1:0] {IDLE, ARM, COUNT, REPORT} state_t;

    state_t                 state, state_nx;
    logic [ARM_W-1:0]       arm_cnt, arm_cnt_nx;
    logic [WIN_W-1:0]       win_cnt, win_cnt_nx;
    logic [CNT_W-1:0]       edge_cnt, edge_cnt_nx;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], I};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_comb begin
        state_nx    = state;
        arm_cnt_nx  = arm_cnt;
        win_cnt_nx  = win_cnt;
        edge_cnt_nx = edge_cnt;
        case (state)
            IDLE: begin
                if (EN) begin
                    state_nx   = ARM;
                    arm_cnt_nx = '0;
                end
            end
            ARM: begin
                if (!EN) begin
                    state_nx = IDLE;
                end else if (arm_cnt == ARM_LAST) begin
                    state_nx    = COUNT;
                    win_cnt_nx  = '0;
                    edge_cnt_nx = '0;
                end else begin
                    arm_cnt_nx = arm_cnt + 1'b1;
                end
            end
            COUNT: begin
                if (!EN) begin
                    state_nx = IDLE;
                end else begin
                    if (rise && !(&edge_cnt)) edge_cnt_nx = edge_cnt + 1'b1;
                    if (win_cnt == WIN_LAST) state_nx = REPORT;
                    else win_cnt_nx = win_cnt + 1'b1;
                end
            end
            REPORT: begin
                // A rise seen while reporting seeds the next window so none is lost.
                if (EN) begin
                    state_nx    = COUNT;
                    win_cnt_nx  = '0;
                    edge_cnt_nx = CNT_W'(rise);
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            arm_cnt  <= '0;
            win_cnt  <= '0;
            edge_cnt <= '0;
        end else begin
            state    <= state_nx;
            arm_cnt  <= arm_cnt_nx;
            win_cnt  <= win_cnt_nx;
            edge_cnt <= edge_cnt_nx;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            CNT   <= '0;
            VALID <= 1'b0;
            FAIL  <= 1'b0;
            STUCK <= 1'b0;
        end else begin
            VALID <= (state == REPORT);
            if (state == REPORT) begin
                CNT   <= edge_cnt;
                FAIL  <= (edge_cnt < LO_TH) || (edge_cnt > HI_TH);
                STUCK <= (edge_cnt == '0);
            end
        end
    end

    assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_clkmon_edge_counter.sv
// Directed bench for clkmon_edge_counter: vector table of single windows plus
// hand sequences for back-to-back windows, EN drop, mid-window reset and saturation.
module tb_clkmon_edge_counter;
    localparam int WIN       = 256;
    localparam int SYNC      = 2;
    localparam int FIRST_LAT = 1 + SYNC + WIN + 1;
    localparam int GAP       = WIN + 1;
    localparam int BUDGET    = 1000;
    localparam int NVEC      = 13;

    typedef struct {
        int         mode;
        int         period;
        int         phase;
        logic [7:0] lo;
        logic [7:0] hi;
        logic [7:0] cnt;
        logic       fail;
        logic       stuck;
    } vec_t;

    vec_t vecs[NVEC];

    logic       clk = 1'b0;
    logic       rst, en, i_net;
    logic [7:0] lo_th, hi_th, cnt;
    logic       valid, fail, stuck, busy;
    logic [4:0] lo2, hi2, cnt2;
    logic       valid2, fail2, stuck2, busy2;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int i_mode = 0;
    int i_period = 4;
    int i_phase = 0;
    int i_base = 0;

    always #5 clk = ~clk;

    clkmon_edge_counter #(.WIN_CYCLES(WIN), .CNT_W(8), .SYNC_STAGES(SYNC)) dut (
        .CLK(clk), .RST(rst), .EN(en), .I(i_net), .LO_TH(lo_th), .HI_TH(hi_th),
        .CNT(cnt), .VALID(valid), .FAIL(fail), .STUCK(stuck), .BUSY(busy)
    );

    clkmon_edge_counter #(.WIN_CYCLES(WIN), .CNT_W(5), .SYNC_STAGES(SYNC)) dut_sat (
        .CLK(clk), .RST(rst), .EN(en), .I(i_net), .LO_TH(lo2), .HI_TH(hi2),
        .CNT(cnt2), .VALID(valid2), .FAIL(fail2), .STUCK(stuck2), .BUSY(busy2)
    );

    // mode 0: low, 1: high, 2: square wave of i_period CLK cycles
    initial begin
        i_net = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            case (i_mode)
                0:       i_net = 1'b0;
                1:       i_net = 1'b1;
                default: i_net = ((cyc - i_base + i_phase) % i_period) < (i_period / 2);
            endcase
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic wait_valid(output int n, output bit got);
        n   = 0;
        got = 1'b0;
        while (!got && n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
            if (valid) got = 1'b1;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int         n;
        bit         got;
        int         sum;
        int         vseen;
        logic [7:0] c;

        vecs[0]  = '{2,   4, 0, 8'd60, 8'd68,  8'd64, 1'b0, 1'b0};
        vecs[1]  = '{0,   4, 0, 8'd60, 8'd68,  8'd0,  1'b1, 1'b1};
        vecs[2]  = '{1,   4, 0, 8'd0,  8'd255, 8'd0,  1'b0, 1'b1};
        vecs[3]  = '{2,   8, 0, 8'd32, 8'd32,  8'd32, 1'b0, 1'b0};
        vecs[4]  = '{2, 256, 0, 8'd1,  8'd1,   8'd1,  1'b0, 1'b0};
        vecs[5]  = '{2,   4, 0, 8'd64, 8'd64,  8'd64, 1'b0, 1'b0};
        vecs[6]  = '{2,   4, 0, 8'd65, 8'd70,  8'd64, 1'b1, 1'b0};
        vecs[7]  = '{2,   4, 0, 8'd0,  8'd63,  8'd64, 1'b1, 1'b0};
        vecs[8]  = '{2,   4, 0, 8'd70, 8'd50,  8'd64, 1'b1, 1'b0};
        vecs[9]  = '{2,   4, 1, 8'd70, 8'd50,  8'd64, 1'b1, 1'b0};
        vecs[10] = '{2,   4, 2, 8'd70, 8'd50,  8'd64, 1'b1, 1'b0};
        vecs[11] = '{2,   4, 3, 8'd70, 8'd50,  8'd64, 1'b1, 1'b0};
        vecs[12] = '{2,  16, 0, 8'd0,  8'd0,   8'd16, 1'b1, 1'b0};

        rst = 1'b1; en = 1'b0; lo_th = '0; hi_th = '0; lo2 = '0; hi2 = '0;

        for (int k = 0; k < NVEC; k++) begin
            lo_th    = vecs[k].lo;
            hi_th    = vecs[k].hi;
            i_mode   = vecs[k].mode;
            i_period = vecs[k].period;
            i_phase  = vecs[k].phase;
            i_base   = cyc;
            apply_reset();
            check($sformatf("v%0d_reset", k), {cnt, valid, fail, stuck, busy}, 0);
            rst = 1'b0;
            en  = 1'b1;
            wait_valid(n, got);
            check($sformatf("v%0d_valid_seen", k), got, 1);
            check($sformatf("v%0d_latency", k), n, FIRST_LAT);
            check($sformatf("v%0d_cnt", k), cnt, vecs[k].cnt);
            check($sformatf("v%0d_fail", k), fail, vecs[k].fail);
            check($sformatf("v%0d_stuck", k), stuck, vecs[k].stuck);
            check($sformatf("v%0d_busy", k), busy, 1);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid_pulse", k), valid, 0);
        end

        // Back-to-back windows: 257-cycle spacing, every later window covers 257 samples.
        lo_th = 8'd60; hi_th = 8'd68;
        i_mode = 2; i_period = 4; i_phase = 1; i_base = cyc;
        apply_reset();
        rst = 1'b0; en = 1'b1;
        wait_valid(n, got);
        check("b2b_first_seen", got, 1);
        check("b2b_first_cnt", cnt, 64);
        sum = 0;
        for (int w = 0; w < 4; w++) begin
            wait_valid(n, got);
            c = cnt;
            check($sformatf("b2b_w%0d_gap", w), n, GAP);
            check($sformatf("b2b_w%0d_cnt_range", w), (c == 8'd64 || c == 8'd65), 1);
            check($sformatf("b2b_w%0d_fail", w), fail, 0);
            sum += int'(c);
        end
        check("b2b_sum4", sum, 257);

        // Stuck net, then toggling after an EN drop.
        i_mode = 0;
        apply_reset();
        rst = 1'b0; en = 1'b1;
        wait_valid(n, got);
        check("stuck_seen", got, 1);
        check("stuck_cnt", cnt, 0);
        check("stuck_stuck", stuck, 1);
        check("stuck_fail", fail, 1);
        en = 1'b0;
        i_mode = 2; i_period = 4; i_phase = 0; i_base = cyc;
        @(posedge clk);
        #1;
        check("stuck_busy_off", busy, 0);
        check("stuck_held", {cnt, fail, stuck}, {8'd0, 1'b1, 1'b1});
        repeat (5) @(posedge clk);
        #1;
        en = 1'b1;
        wait_valid(n, got);
        check("recover_latency", n, FIRST_LAT);
        check("recover_cnt", cnt, 64);
        check("recover_stuck", stuck, 0);
        check("recover_fail", fail, 0);

        // EN dropped around COUNT cycle 100: no report, outputs hold.
        lo_th = 8'd70; hi_th = 8'd80;
        vseen = 0;
        repeat (99) begin
            @(posedge clk);
            #1;
            if (valid) vseen++;
        end
        en = 1'b0;
        @(posedge clk);
        #1;
        if (valid) vseen++;
        check("endrop_busy_off", busy, 0);
        repeat (300) begin
            @(posedge clk);
            #1;
            if (valid) vseen++;
        end
        check("endrop_no_valid", vseen, 0);
        check("endrop_held", {cnt, fail, stuck}, {8'd64, 1'b0, 1'b0});
        en = 1'b1;
        wait_valid(n, got);
        check("endrop_rearm_latency", n, FIRST_LAT);
        check("endrop_rearm_cnt", cnt, 64);
        check("endrop_rearm_fail", fail, 1);

        // Reset pulse mid-COUNT with EN held high.
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_outputs", {cnt, valid, fail, stuck, busy}, 0);
        rst = 1'b0;
        wait_valid(n, got);
        check("midrst_latency", n, FIRST_LAT);
        check("midrst_cnt", cnt, 64);

        // Saturation on a 5-bit counter: ~51 edges clip to 31.
        lo_th = 8'd0; hi_th = 8'd255; lo2 = 5'd0; hi2 = 5'd30;
        i_mode = 2; i_period = 5; i_phase = 0; i_base = cyc;
        apply_reset();
        rst = 1'b0; en = 1'b1;
        wait_valid(n, got);
        check("sat_valid_seen", got, 1);
        check("sat_valid2", valid2, 1);
        check("sat_cnt2", cnt2, 31);
        check("sat_fail2", fail2, 1);
        check("sat_stuck2", stuck2, 0);
        check("sat_cnt8_range", (cnt == 8'd51 || cnt == 8'd52), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
